// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the SERV ibus/dbus Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    localparam logic [31:0] WB_ARB_DEAD_DATA = 32'hDEAD_BEEF;
    localparam logic [3:0]  IBUS_SEL         = 4'hF;
    localparam int unsigned TMO_CNT_W        = 16;

endpackage

// File: rtl/wb_arb_timeout.sv
// Grant-duration counter for the arbiter: cleared while idle, counts un-acked granted cycles,
// flags the cycle on which the granted-cycle count reaches TIMEOUT.
module wb_arb_timeout
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expired
);

    // Count starts at 0 on the first granted cycle, so cycle N sees N-1.
    localparam logic [TMO_CNT_W-1:0] LAST_CNT = TMO_CNT_W'(TIMEOUT - 1);

    logic [TMO_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_count) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expired = (cnt_q == LAST_CNT);

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master Wishbone arbiter (SERV ibus + dbus onto one port), round-robin or dbus priority.
// Optional grant timeout enabled by defining WB_ARB_TIMEOUT_EN.
module wb_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned RR      = 1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_wb_ibus_adr,
    input  logic        i_wb_ibus_cyc,
    output logic [31:0] o_wb_ibus_rdt,
    output logic        o_wb_ibus_ack,
    input  logic [31:0] i_wb_dbus_adr,
    input  logic [31:0] i_wb_dbus_dat,
    input  logic [3:0]  i_wb_dbus_sel,
    input  logic        i_wb_dbus_we,
    input  logic        i_wb_dbus_cyc,
    output logic [31:0] o_wb_dbus_rdt,
    output logic        o_wb_dbus_ack,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic        o_timeout
);

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wb_bus_arbiter: TIMEOUT must be in 1..65535");
    end

    arb_state_e state_q, state_d;
    logic       last_dbus_q, last_dbus_d;   // 1: dbus was granted last
    logic       gnt_i, gnt_d, gnt_cyc, tmo;

    assign gnt_i   = (state_q == GNT_I);
    assign gnt_d   = (state_q == GNT_D);
    assign gnt_cyc = (gnt_i && i_wb_ibus_cyc) || (gnt_d && i_wb_dbus_cyc);

`ifdef WB_ARB_TIMEOUT_EN
    logic tmo_expired;

    wb_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (state_q == IDLE),
        .i_count   (gnt_cyc && !i_wb_ack),
        .o_expired (tmo_expired)
    );

    // A real ack in the terminal cycle takes precedence over the forced one.
    assign tmo = tmo_expired && gnt_cyc && !i_wb_ack;
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        last_dbus_d = last_dbus_q;
        unique case (state_q)
            IDLE: begin
                if (i_wb_ibus_cyc && i_wb_dbus_cyc) begin
                    if (RR != 0) begin
                        state_d = last_dbus_q ? GNT_I : GNT_D;
                    end else begin
                        state_d = GNT_D;
                    end
                end else if (i_wb_dbus_cyc) begin
                    state_d = GNT_D;
                end else if (i_wb_ibus_cyc) begin
                    state_d = GNT_I;
                end
            end
            GNT_I: begin
                if (i_wb_ack || tmo || !i_wb_ibus_cyc) begin
                    state_d = IDLE;
                    if (i_wb_ack || tmo) begin
                        last_dbus_d = 1'b0;
                    end
                end
            end
            GNT_D: begin
                if (i_wb_ack || tmo || !i_wb_dbus_cyc) begin
                    state_d = IDLE;
                    if (i_wb_ack || tmo) begin
                        last_dbus_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            last_dbus_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_dbus_q <= last_dbus_d;
        end
    end

    always_comb begin
        o_wb_adr      = gnt_i ? i_wb_ibus_adr : i_wb_dbus_adr;
        o_wb_dat      = i_wb_dbus_dat;
        o_wb_sel      = gnt_i ? IBUS_SEL : i_wb_dbus_sel;
        o_wb_we       = gnt_d && i_wb_dbus_we;
        o_wb_cyc      = gnt_cyc && !tmo;
        o_wb_ibus_ack = gnt_i && (i_wb_ack || tmo);
        o_wb_dbus_ack = gnt_d && (i_wb_ack || tmo);
        o_wb_ibus_rdt = tmo ? WB_ARB_DEAD_DATA : i_wb_rdt;
        o_wb_dbus_rdt = tmo ? WB_ARB_DEAD_DATA : i_wb_rdt;
        o_timeout     = tmo;
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: a round-robin and a fixed-priority instance share stimulus.
module tb_wb_bus_arbiter;

    localparam logic [31:0] IADR = 32'h0000_0100;
    localparam logic [31:0] DADR = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ibus_cyc, dbus_cyc, dbus_we, wb_ack;
    logic [31:0] ibus_adr, dbus_adr, dbus_dat, wb_rdt;
    logic [3:0]  dbus_sel;

    logic [31:0] r_irdt, r_drdt, r_adr, r_dat;
    logic        r_iack, r_dack, r_we, r_cyc, r_tmo;
    logic [3:0]  r_sel;
    logic [31:0] f_irdt, f_drdt, f_adr, f_dat;
    logic        f_iack, f_dack, f_we, f_cyc, f_tmo;
    logic [3:0]  f_sel;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    wb_bus_arbiter #(.RR(1), .TIMEOUT(8)) dut_rr (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wb_ibus_adr(ibus_adr), .i_wb_ibus_cyc(ibus_cyc),
        .o_wb_ibus_rdt(r_irdt), .o_wb_ibus_ack(r_iack),
        .i_wb_dbus_adr(dbus_adr), .i_wb_dbus_dat(dbus_dat), .i_wb_dbus_sel(dbus_sel),
        .i_wb_dbus_we(dbus_we), .i_wb_dbus_cyc(dbus_cyc),
        .o_wb_dbus_rdt(r_drdt), .o_wb_dbus_ack(r_dack),
        .o_wb_adr(r_adr), .o_wb_dat(r_dat), .o_wb_sel(r_sel), .o_wb_we(r_we),
        .o_wb_cyc(r_cyc), .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack), .o_timeout(r_tmo)
    );

    wb_bus_arbiter #(.RR(0), .TIMEOUT(8)) dut_fp (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wb_ibus_adr(ibus_adr), .i_wb_ibus_cyc(ibus_cyc),
        .o_wb_ibus_rdt(f_irdt), .o_wb_ibus_ack(f_iack),
        .i_wb_dbus_adr(dbus_adr), .i_wb_dbus_dat(dbus_dat), .i_wb_dbus_sel(dbus_sel),
        .i_wb_dbus_we(dbus_we), .i_wb_dbus_cyc(dbus_cyc),
        .o_wb_dbus_rdt(f_drdt), .o_wb_dbus_ack(f_dack),
        .o_wb_adr(f_adr), .o_wb_dat(f_dat), .o_wb_sel(f_sel), .o_wb_we(f_we),
        .o_wb_cyc(f_cyc), .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack), .o_timeout(f_tmo)
    );

    typedef struct {
        logic        ic;
        logic        dc;
        logic        ack;
        logic [31:0] rdt;
        logic        e_cyc;
        logic [31:0] e_adr;
        logic [3:0]  e_sel;
        logic        e_we;
        logic        e_iack;
        logic        e_dack;
    } vec_t;

    vec_t tv[16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ic dc ack rdt | cyc adr sel we iack dack   (RR instance, last grant = ibus at start)
        tv[0]  = '{1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{1'b0, 1'b1, 1'b1, 32'h0,         1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0};
        tv[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, DADR,  4'h1, 1'b1, 1'b0, 1'b0};
        tv[3]  = '{1'b0, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b1, DADR,  4'h1, 1'b1, 1'b0, 1'b1};
        tv[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0};
        tv[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, IADR,  4'hF, 1'b0, 1'b0, 1'b0};
        tv[6]  = '{1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b1, IADR,  4'hF, 1'b0, 1'b1, 1'b0};
        tv[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0};
        tv[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, DADR,  4'h1, 1'b1, 1'b0, 1'b0};
        tv[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0};
        tv[10] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0};
        tv[11] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, DADR,  4'h1, 1'b1, 1'b0, 1'b0};
        tv[12] = '{1'b1, 1'b1, 1'b1, 32'hAAAA_0001, 1'b1, DADR,  4'h1, 1'b1, 1'b0, 1'b1};
        tv[13] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0};
        tv[14] = '{1'b1, 1'b1, 1'b1, 32'hBBBB_0002, 1'b1, IADR,  4'hF, 1'b0, 1'b1, 1'b0};
        tv[15] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0};

        rst_n    = 1'b0;
        ibus_adr = IADR;
        ibus_cyc = 1'b1;
        dbus_adr = DADR;
        dbus_dat = 32'h1;
        dbus_sel = 4'h1;
        dbus_we  = 1'b1;
        dbus_cyc = 1'b1;
        wb_ack   = 1'b0;
        wb_rdt   = 32'h0;

        // Reset held with both masters requesting
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst%0d cyc", i), 32'(r_cyc), 32'd0);
            check($sformatf("rst%0d acks", i), {30'd0, r_iack, r_dack}, 32'd0);
            check($sformatf("rst%0d tmo", i), 32'(r_tmo), 32'd0);
        end
        rst_n = 1'b1;
        #1;
        check("release idle cyc", 32'(r_cyc), 32'd0);

        // Both held for four transactions: RR D,I,D,I; fixed D,D,D,D; bubble between each
        for (int t = 0; t < 4; t++) begin
            tick();
            check($sformatf("rr t%0d cyc", t), 32'(r_cyc), 32'd1);
            check($sformatf("rr t%0d adr", t), r_adr, (t % 2 == 0) ? DADR : IADR);
            check($sformatf("fp t%0d cyc", t), 32'(f_cyc), 32'd1);
            check($sformatf("fp t%0d adr", t), f_adr, DADR);
            wb_ack = 1'b1;
            #1;
            check($sformatf("rr t%0d acks", t), {30'd0, r_iack, r_dack},
                  (t % 2 == 0) ? 32'd1 : 32'd2);
            check($sformatf("fp t%0d acks", t), {30'd0, f_iack, f_dack}, 32'd1);
            tick();
            wb_ack = 1'b0;
            #1;
            check($sformatf("rr t%0d bubble", t), 32'(r_cyc), 32'd0);
            check($sformatf("fp t%0d bubble", t), 32'(f_cyc), 32'd0);
        end

        for (int i = 0; i < 16; i++) begin
            ibus_cyc = tv[i].ic;
            dbus_cyc = tv[i].dc;
            wb_ack   = tv[i].ack;
            wb_rdt   = tv[i].rdt;
            #1;
            check($sformatf("v%0d cyc", i), 32'(r_cyc), 32'(tv[i].e_cyc));
            check($sformatf("v%0d iack", i), 32'(r_iack), 32'(tv[i].e_iack));
            check($sformatf("v%0d dack", i), 32'(r_dack), 32'(tv[i].e_dack));
            check($sformatf("v%0d tmo", i), 32'(r_tmo), 32'd0);
            if (tv[i].e_cyc) begin
                check($sformatf("v%0d adr", i), r_adr, tv[i].e_adr);
                check($sformatf("v%0d sel", i), 32'(r_sel), 32'(tv[i].e_sel));
                check($sformatf("v%0d we", i), 32'(r_we), 32'(tv[i].e_we));
                if (tv[i].e_adr == DADR) check($sformatf("v%0d dat", i), r_dat, 32'h1);
            end
            if (tv[i].e_iack) check($sformatf("v%0d irdt", i), r_irdt, tv[i].rdt);
            if (tv[i].e_dack) check($sformatf("v%0d drdt", i), r_drdt, tv[i].rdt);
            tick();
        end

        // Slave never acks
        wb_ack   = 1'b0;
        wb_rdt   = 32'h1111_1111;
        dbus_cyc = 1'b1;
        #1;
        check("to idle cyc", 32'(r_cyc), 32'd0);
        for (int c = 1; c < 8; c++) begin
            tick();
            check($sformatf("to c%0d cyc", c), 32'(r_cyc), 32'd1);
            check($sformatf("to c%0d dack", c), 32'(r_dack), 32'd0);
            check($sformatf("to c%0d tmo", c), 32'(r_tmo), 32'd0);
        end
        tick();
`ifdef WB_ARB_TIMEOUT_EN
        check("to c8 dack", 32'(r_dack), 32'd1);
        check("to c8 drdt", r_drdt, 32'hDEAD_BEEF);
        check("to c8 cyc", 32'(r_cyc), 32'd0);
        check("to c8 tmo", 32'(r_tmo), 32'd1);
        tick();
        check("to after cyc", 32'(r_cyc), 32'd0);
        check("to after tmo", 32'(r_tmo), 32'd0);
        check("to after dack", 32'(r_dack), 32'd0);
`else
        for (int c = 8; c < 12; c++) begin
            check($sformatf("hang c%0d cyc", c), 32'(r_cyc), 32'd1);
            check($sformatf("hang c%0d dack", c), 32'(r_dack), 32'd0);
            check($sformatf("hang c%0d tmo", c), 32'(r_tmo), 32'd0);
            tick();
        end
        wb_ack = 1'b1;
        #1;
        check("hang ack", 32'(r_dack), 32'd1);
        tick();
        wb_ack = 1'b0;
        #1;
        check("hang bubble", 32'(r_cyc), 32'd0);
`endif

        // Real ack on the terminal cycle wins over the timeout
        for (int c = 1; c < 8; c++) begin
            tick();
            check($sformatf("ak c%0d dack", c), 32'(r_dack), 32'd0);
        end
        tick();
        wb_ack = 1'b1;
        wb_rdt = 32'h55AA_55AA;
        #1;
        check("ak c8 dack", 32'(r_dack), 32'd1);
        check("ak c8 drdt", r_drdt, 32'h55AA_55AA);
        check("ak c8 tmo", 32'(r_tmo), 32'd0);
        check("ak c8 cyc", 32'(r_cyc), 32'd1);
        tick();
        wb_ack   = 1'b0;
        dbus_cyc = 1'b0;
        #1;
        check("ak bubble", 32'(r_cyc), 32'd0);

        // Reset mid-transaction, request survives and is regranted
        dbus_cyc = 1'b1;
        tick();
        check("mr granted", 32'(r_cyc), 32'd1);
        rst_n = 1'b0;
        tick();
        check("mr reset cyc", 32'(r_cyc), 32'd0);
        check("mr reset dack", 32'(r_dack), 32'd0);
        rst_n = 1'b1;
        tick();
        check("mr regrant cyc", 32'(r_cyc), 32'd1);
        check("mr regrant adr", r_adr, DADR);
        dbus_cyc = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
